xtea_block_sequencer: RTL

Hardware sequencer that drives the XTEA core directly, replacing the byte-by-byte soft-processor controller on the key/FIFO/result path. On a go command it loads the 128-bit key from the key RAM and pulls 8-byte blocks from the inter-processor FIFO. For each block it starts the core, waits for completion and writes the 8 result bytes to the result RAM. It reports progress, completion and a core-timeout error.

---
 rtl/xtea_seq_pkg.sv | 26 ++
 rtl/xtea_seq_timeout.sv | 41 ++++
 rtl/xtea_block_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/xtea_seq_pkg.sv
// rtl/xtea_seq_pkg.sv - shared types and constants for the XTEA block sequencer
//
// Purpose: sequencer state encoding, key/block byte counts and the default
//          core watchdog limit.
// Ports:   none (package).
package xtea_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    KEY_ADDR,
    KEY_CAP,
    DATA_POP,
    DATA_CAP,
    START,
    WAIT_LO,
    WAIT_HI,
    WRITE,
    NEXT,
    DONE
  } state_t;

  localparam int KEY_BYTES           = 16;
  localparam int BLK_BYTES           = 8;
  localparam int TIMEOUT_CYCLES_DEF  = 1024;

endpackage

// File: rtl/xtea_seq_timeout.sv
// rtl/xtea_seq_timeout.sv - loadable watchdog counter for the XTEA core handshake
//
// Purpose: counts enabled cycles; expire is raised on the cycle after which
//          the count would reach LIMIT.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         force count to zero (highest priority after reset)
//   load          load count with load_val
//   en            advance count by one (saturates at LIMIT)
//   load_val      value taken on load
//   expire        enabled cycle whose increment reaches LIMIT
module xtea_seq_timeout #(
  parameter int LIMIT = 1024,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

  assign expire = en && (count >= W'(LIMIT - 1));

endmodule

// File: rtl/xtea_block_sequencer.sv
// rtl/xtea_block_sequencer.sv - key/FIFO/result sequencer driving the XTEA core
//
// Purpose: on go, loads the 128-bit key from key RAM, then for each 8-byte
//          block pops the FIFO, runs the core and writes the result bytes to
//          result RAM. Reports busy, done, blocks_done and a sticky core
//          timeout error.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   go, decrypt, num_blocks,
//   key_base, dst_base         job request and parameters (latched on go)
//   key_addr, key_data         key RAM read port (1-cycle read latency)
//   fifo_rd_en, fifo_dout,
//   fifo_empty                 inter-processor FIFO pop port
//   xtea_key, xtea_data_in,
//   xtea_start, xtea_mode,
//   xtea_data_out, xtea_ready  XTEA core interface
//   res_addr, res_din, res_we  result RAM write port
//   busy, done, error,
//   blocks_done                job status
module xtea_block_sequencer
  import xtea_seq_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              decrypt,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic [ADDR_W-1:0] key_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] key_addr,
  input  logic [7:0]        key_data,
  output logic              fifo_rd_en,
  input  logic [7:0]        fifo_dout,
  input  logic              fifo_empty,
  output logic [127:0]      xtea_key,
  output logic [63:0]       xtea_data_in,
  output logic              xtea_start,
  output logic              xtea_mode,
  input  logic [63:0]       xtea_data_out,
  input  logic              xtea_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_din,
  output logic              res_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  blocks_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_nx;
  logic [3:0]        idx;
  logic              dec_q;
  logic [CNT_W-1:0]  num_q;
  logic [ADDR_W-1:0] key_base_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [63:0]       result_q;
  logic              tmo_expire;
  logic              timeout_hit;
  logic              key_last;
  logic              blk_last;

  assign key_last  = (idx == 4'(KEY_BYTES - 1));
  assign blk_last  = (idx == 4'(BLK_BYTES - 1));
  assign busy      = (state != IDLE);
  assign xtea_mode = dec_q;

  // The watchdog is loaded with 1 on the start cycle so that its count equals
  // the number of cycles elapsed since xtea_start.
  xtea_seq_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TW)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .load     (state == START),
    .en       ((state == WAIT_LO) || (state == WAIT_HI)),
    .load_val (TW'(1)),
    .expire   (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    key_addr    = '0;
    fifo_rd_en  = 1'b0;
    xtea_start  = 1'b0;
    res_we      = 1'b0;
    res_addr    = '0;
    res_din     = '0;
    done        = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nx = (num_blocks == '0) ? DONE : KEY_ADDR;
        end
      end
      KEY_ADDR: begin
        key_addr = key_base_q + ADDR_W'(idx);
        state_nx = KEY_CAP;
      end
      KEY_CAP: begin
        state_nx = key_last ? DATA_POP : KEY_ADDR;
      end
      DATA_POP: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nx   = DATA_CAP;
        end
      end
      DATA_CAP: begin
        state_nx = blk_last ? START : DATA_POP;
      end
      START: begin
        xtea_start = 1'b1;
        state_nx   = WAIT_LO;
      end
      WAIT_LO: begin
        if (!xtea_ready) begin
          state_nx = WAIT_HI;
        end else if (tmo_expire) begin
          timeout_hit = 1'b1;
          state_nx    = DONE;
        end
      end
      WAIT_HI: begin
        // A result arriving on the expiry cycle still counts as completion.
        if (xtea_ready) begin
          state_nx = WRITE;
        end else if (tmo_expire) begin
          timeout_hit = 1'b1;
          state_nx    = DONE;
        end
      end
      WRITE: begin
        res_we   = 1'b1;
        res_addr = wr_ptr;
        res_din  = result_q[{idx[2:0], 3'b000} +: 8];
        if (blk_last) begin
          state_nx = NEXT;
        end
      end
      NEXT: begin
        state_nx = ((blocks_done + CNT_W'(1)) == num_q) ? DONE : DATA_POP;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      dec_q        <= 1'b0;
      num_q        <= '0;
      key_base_q   <= '0;
      wr_ptr       <= '0;
      xtea_key     <= '0;
      xtea_data_in <= '0;
      result_q     <= '0;
      error        <= 1'b0;
      blocks_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            dec_q       <= decrypt;
            num_q       <= num_blocks;
            key_base_q  <= key_base;
            wr_ptr      <= dst_base;
            error       <= 1'b0;
            blocks_done <= '0;
            idx         <= '0;
          end
        end
        KEY_CAP: begin
          xtea_key[{idx, 3'b000} +: 8] <= key_data;
          idx <= idx + 4'd1;
        end
        DATA_CAP: begin
          xtea_data_in[{idx[2:0], 3'b000} +: 8] <= fifo_dout;
          idx <= blk_last ? 4'd0 : idx + 4'd1;
        end
        WAIT_HI: begin
          if (xtea_ready) begin
            result_q <= xtea_data_out;
          end
        end
        WRITE: begin
          // The write pointer runs continuously across blocks, giving
          // dst_base + 8*blk + k with natural wrap.
          wr_ptr <= wr_ptr + ADDR_W'(1);
          idx    <= blk_last ? 4'd0 : idx + 4'd1;
        end
        NEXT: begin
          blocks_done <= blocks_done + CNT_W'(1);
        end
        default: ;
      endcase
      if (timeout_hit) begin
        error <= 1'b1;
      end
    end
  end

endmodule
